dii_mux_rr_n: RTL
=================

DII_MUX_RR_N -- requirements
Module: dii_mux_rr_n

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of flit inputs (legal range 2..16).
REQ-002 SHALL have parameter PRIO_RESET, default 0, round-robin pointer value after reset (0..CHANNELS-1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_flit  input  dii_flit[CHANNELS]  per-channel flit (valid, last, data).
REQ-006 SHALL have port in_ready  output  CHANNELS  per-channel accept.
REQ-007 SHALL have port out_flit  output  dii_flit  muxed flit.
REQ-008 SHALL have port out_ready  input  1  downstream accept.
REQ-009 SHALL have port busy  output  1  high while a worm is locked (state WORM).
REQ-010 SHALL have port owner  output  $clog2(CHANNELS)  locked channel index; equals pointer when not busy.

Function
REQ-011 SHALL implement states IDLE and WORM, a registered owner index, and a registered round-robin pointer ptr.
REQ-012 SHALL transfer a flit only in a cycle where the presented valid and the accepting ready are both high.
REQ-013 SHALL, in IDLE, grant the first channel with valid high when searching ptr, ptr+1, ... modulo CHANNELS.
REQ-014 SHALL, in IDLE with a grant, present in_flit[winner] on out_flit and drive in_ready[winner]=out_ready, all other in_ready 0.
REQ-015 SHALL, in IDLE with no valid input, drive out_flit.valid=0, out_flit.last=0, out_flit.data=0, and all in_ready 0.
REQ-016 SHALL, in IDLE, move to WORM with owner=winner when the granted flit is not transferred, or is transferred with last=0.
REQ-017 SHALL, in IDLE, stay in IDLE and set ptr=(winner+1) mod CHANNELS when the granted flit is transferred with last=1.
REQ-018 SHALL, in WORM, present in_flit[owner] unchanged, including valid=0 bubbles, and drive in_ready[owner]=out_ready, all others 0.
REQ-019 SHALL, in WORM, ignore valid on all non-owner channels.
REQ-020 SHALL, in WORM, return to IDLE and set ptr=(owner+1) mod CHANNELS on transfer of a flit with last=1.
REQ-021 SHALL never change owner while in WORM, so no worm is interleaved with another.
REQ-022 SHALL perform the modulo wrap ptr=CHANNELS-1 -> 0 correctly for non-power-of-two CHANNELS.
REQ-023 SHALL add zero cycles of latency (combinational path input to output) when the REQ-029 macro is undefined.

Reset
REQ-024 SHALL, while rst is high, force state=IDLE, ptr=PRIO_RESET, owner=PRIO_RESET.
REQ-025 SHALL, while rst is high, drive all in_ready 0, out_flit.valid 0, and busy 0.
REQ-026 SHALL, on reset asserted mid-worm, abandon the worm; the first post-reset grant follows REQ-013 from PRIO_RESET.

Configuration
REQ-027 SHALL support macro DII_MUX_RR_N_OUTREG_EN.
REQ-028 SHALL, without the macro, behave per REQ-023: out_flit is combinational from the selected input.
REQ-029 SHALL, with the macro, drive out_flit from a one-entry output register.
REQ-030 SHALL, with the macro, load the register when it is empty or out_ready is high, giving 1-cycle latency and full throughput.
REQ-031 SHALL, with the macro, drive in_ready[selected] = register empty OR out_ready.
REQ-032 SHALL, with the macro, evaluate state transitions on the input-side transfer (in_flit valid AND in_ready), not on the output-side transfer.
REQ-033 SHALL, with the macro, clear register valid on reset.

Verification
REQ-034 SHALL test, with CHANNELS=4, ptr=0, out_ready=1: single-flit packets valid on ch1 and ch3 -> ch1 sent, then ch3 sent, ptr=0 afterwards.
REQ-035 SHALL test: a 3-flit worm on ch2 with ch0 valid throughout -> flits 2a, 2b, 2c contiguous on out, ch0 in_ready=0 until 2c is sent, then ch0 granted.
REQ-036 SHALL test: ch2 worm with an invalid bubble in cycle 2 -> out_flit.valid=0 that cycle, busy stays 1, owner=2.
REQ-037 SHALL test: out_ready=0 for 5 cycles while ch1's first flit (last=0) is pending and ch0 becomes valid -> out_flit holds ch1 data stable and busy=1.
REQ-038 SHALL test: rst asserted on the second flit of a ch3 worm -> next cycle busy=0, ptr=PRIO_RESET, all in_ready=0 during reset.
REQ-039 SHALL test, with DII_MUX_RR_N_OUTREG_EN and CHANNELS=3: continuous ch1 traffic with out_ready=1 -> one flit per cycle with 1-cycle latency.
REQ-040 SHALL test, with DII_MUX_RR_N_OUTREG_EN and CHANNELS=3: out_ready=0 -> at most one flit accepted, then in_ready[1]=0.

Source files
------------

// File: rtl/dii_mux_rr_n.sv
// dii_mux_rr_n: round-robin, worm-locking mux of CHANNELS DII flit streams.
// Define DII_MUX_RR_N_OUTREG_EN to drive out_flit from a one-entry output register.
package dii_pkg;
    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;
endpackage

module dii_mux_rr_n
    import dii_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int PRIO_RESET = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  dii_flit                     in_flit [CHANNELS],
    output logic [CHANNELS-1:0]         in_ready,
    output dii_flit                     out_flit,
    input  logic                        out_ready,
    output logic                        busy,
    output logic [$clog2(CHANNELS)-1:0] owner
);
    localparam int IW = $clog2(CHANNELS);
    typedef enum logic {IDLE, WORM} state_t;
    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_ptr, r_owner, w_ptr_nxt, w_owner_nxt, w_winner, w_sel;
    logic          w_found, w_grant, w_accept, w_xfer;
    dii_flit       w_sel_flit;

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
        return (int'(i) == CHANNELS - 1) ? '0 : i + 1'b1;
    endfunction

    // Descending scan so the smallest offset from r_ptr wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (in_flit[(int'(r_ptr) + k) % CHANNELS].valid) begin
                w_found  = 1'b1;
                w_winner = IW'((int'(r_ptr) + k) % CHANNELS);
            end
        end
    end

    assign w_sel      = (r_state == WORM) ? r_owner : w_winner;
    assign w_sel_flit = in_flit[w_sel];
    assign w_grant    = !rst && (r_state == WORM || w_found);
    assign w_xfer     = w_grant && w_sel_flit.valid && w_accept;

    always_comb begin
        in_ready        = '0;
        in_ready[w_sel] = w_grant && w_accept;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        if (w_xfer && w_sel_flit.last) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = inc(w_sel);
        end else if (r_state == IDLE && w_found) begin
            w_state_nxt = WORM;
            w_owner_nxt = w_winner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= IW'(PRIO_RESET);
            r_owner <= IW'(PRIO_RESET);
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    assign busy  = !rst && r_state == WORM;
    assign owner = busy ? r_owner : r_ptr;

`ifdef DII_MUX_RR_N_OUTREG_EN
    dii_flit r_out;
    assign w_accept = !r_out.valid || out_ready;
    always_ff @(posedge clk) begin
        if (rst)
            r_out <= '0;
        else if (w_accept)
            r_out <= (w_grant && w_sel_flit.valid) ? w_sel_flit : '0;
    end
    always_comb begin
        out_flit       = r_out;
        out_flit.valid = r_out.valid && !rst;
    end
`else
    assign w_accept = out_ready;
    assign out_flit = w_grant ? w_sel_flit : '0;
`endif
endmodule
